// File: rtl/frame_sched_pkg.sv
// rtl/frame_sched_pkg.sv - shared types and defaults for the frame draw scheduler
//   state_t      : 3-bit FSM state encoding
//   *_DEF        : default slot count, sprite size and index width
//   ERASE_COLOR  : colour forced downstream while erase is high
package frame_sched_pkg;

    localparam int NUM_ENEMY_DEF  = 10;
    localparam int SPRITE_PIX_DEF = 16;
    localparam int IDX_W_DEF      = 4;

    localparam logic [2:0] ERASE_COLOR = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_LOAD        = 3'd1,
        S_ERASE_SELF  = 3'd2,
        S_ERASE_ENEMY = 3'd3,
        S_MOVE        = 3'd4,
        S_DRAW_SELF   = 3'd5,
        S_DRAW_ENEMY  = 3'd6,
        S_DONE        = 3'd7
    } state_t;

endpackage

// File: rtl/frame_draw_scheduler_if.sv
// rtl/frame_draw_scheduler_if.sv - game-side inputs and plot-path outputs of the scheduler
//   inputs : start, frame_tick, vis[NUM_ENEMY]
//   outputs: load_coord, move_en, plot, erase, datapath_select, enemy_idx, pix_idx,
//            busy, frame_done, overrun_cnt (only with FRAME_SCHED_OVERRUN_CNT_EN)
//   master : the scheduler; slave : game FSM / datapath side
interface frame_draw_scheduler_if
    import frame_sched_pkg::*;
#(
    parameter int NUM_ENEMY = NUM_ENEMY_DEF,
    parameter int IDX_W     = IDX_W_DEF
);
    logic                 start;
    logic                 frame_tick;
    logic [NUM_ENEMY-1:0] vis;
    logic                 load_coord;
    logic                 move_en;
    logic                 plot;
    logic                 erase;
    logic                 datapath_select;
    logic [IDX_W-1:0]     enemy_idx;
    logic [IDX_W-1:0]     pix_idx;
    logic                 busy;
    logic                 frame_done;
`ifdef FRAME_SCHED_OVERRUN_CNT_EN
    logic [7:0]           overrun_cnt;
`endif

    modport master (
        input  start, frame_tick, vis,
        output load_coord, move_en, plot, erase, datapath_select,
               enemy_idx, pix_idx, busy, frame_done
`ifdef FRAME_SCHED_OVERRUN_CNT_EN
        , output overrun_cnt
`endif
    );

    modport slave (
        output start, frame_tick, vis,
        input  load_coord, move_en, plot, erase, datapath_select,
               enemy_idx, pix_idx, busy, frame_done
`ifdef FRAME_SCHED_OVERRUN_CNT_EN
        , input overrun_cnt
`endif
    );

endinterface

// File: rtl/next_visible_slot.sv
// rtl/next_visible_slot.sv - combinational finder for the next set bit of a mask
//   mask      : visibility mask
//   from_idx  : search starts above this index (at it when inclusive=1)
//   inclusive : include from_idx itself in the search
//   next_idx  : lowest qualifying set bit (0 when none)
//   found     : a qualifying bit exists
module next_visible_slot #(
    parameter int NUM_ENEMY = 10,
    parameter int IDX_W     = 4
) (
    input  logic [NUM_ENEMY-1:0] mask,
    input  logic [IDX_W-1:0]     from_idx,
    input  logic                 inclusive,
    output logic [IDX_W-1:0]     next_idx,
    output logic                 found
);

    always_comb begin
        found    = 1'b0;
        next_idx = '0;
        // Scan downwards so the last hit written is the lowest qualifying slot.
        for (int i = NUM_ENEMY - 1; i >= 0; i--) begin
            if (mask[i] && ((i > int'(from_idx)) || (inclusive && (i == int'(from_idx))))) begin
                found    = 1'b1;
                next_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/frame_draw_scheduler.sv
// rtl/frame_draw_scheduler.sv - per-frame erase/redraw sequencer for the shared VGA plot path
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : frame_draw_scheduler_if.master (start/frame_tick/vis in, plot path out)
//   Optional FRAME_SCHED_OVERRUN_CNT_EN adds a saturating dropped-tick counter.
module frame_draw_scheduler
    import frame_sched_pkg::*;
#(
    parameter int NUM_ENEMY  = NUM_ENEMY_DEF,
    parameter int SPRITE_PIX = SPRITE_PIX_DEF,
    parameter int IDX_W      = IDX_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    frame_draw_scheduler_if.master bus
);

    localparam logic [IDX_W-1:0] PIX_LAST = IDX_W'(SPRITE_PIX - 1);

    state_t               state_q;
    logic [NUM_ENEMY-1:0] vis_q;
    logic                 pending_q;
    logic                 load_coord_q, move_en_q, plot_q, erase_q, dsel_q;
    logic                 busy_q, frame_done_q;
    logic [IDX_W-1:0]     enemy_idx_q, pix_idx_q;

    logic                 fnd_incl, fnd_found;
    logic [IDX_W-1:0]     fnd_from, fnd_idx;
    logic                 launch;

    // At the end of a self pass look for the first visible slot (from 0 inclusive);
    // during an enemy pass look strictly above the slot just drawn.
    assign fnd_incl = (state_q == S_ERASE_SELF) || (state_q == S_DRAW_SELF);
    assign fnd_from = fnd_incl ? '0 : enemy_idx_q;
    assign launch   = bus.start && (bus.frame_tick || pending_q);

    next_visible_slot #(
        .NUM_ENEMY (NUM_ENEMY),
        .IDX_W     (IDX_W)
    ) u_next_visible_slot (
        .mask      (vis_q),
        .from_idx  (fnd_from),
        .inclusive (fnd_incl),
        .next_idx  (fnd_idx),
        .found     (fnd_found)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            vis_q        <= '0;
            pending_q    <= 1'b0;
            load_coord_q <= 1'b0;
            move_en_q    <= 1'b0;
            plot_q       <= 1'b0;
            erase_q      <= 1'b0;
            dsel_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            enemy_idx_q  <= '0;
            pix_idx_q    <= '0;
        end else begin
            load_coord_q <= 1'b0;
            move_en_q    <= 1'b0;
            frame_done_q <= 1'b0;

            // Hold at most one tick that arrives mid-frame; start low discards it.
            if (!bus.start) begin
                pending_q <= 1'b0;
            end else if ((state_q != S_IDLE) && bus.frame_tick) begin
                pending_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        state_q      <= S_LOAD;
                        load_coord_q <= 1'b1;
                        busy_q       <= 1'b1;
                        pending_q    <= 1'b0;
                    end
                end
                S_LOAD, S_MOVE: begin
                    vis_q     <= bus.vis;
                    state_q   <= (state_q == S_LOAD) ? S_ERASE_SELF : S_DRAW_SELF;
                    plot_q    <= 1'b1;
                    erase_q   <= (state_q == S_LOAD);
                    dsel_q    <= 1'b1;
                    pix_idx_q <= '0;
                end
                S_ERASE_SELF, S_ERASE_ENEMY, S_DRAW_SELF, S_DRAW_ENEMY: begin
                    if (pix_idx_q != PIX_LAST) begin
                        pix_idx_q <= pix_idx_q + IDX_W'(1);
                    end else begin
                        pix_idx_q <= '0;
                        dsel_q    <= 1'b0;
                        if (fnd_found) begin
                            state_q     <= erase_q ? S_ERASE_ENEMY : S_DRAW_ENEMY;
                            enemy_idx_q <= fnd_idx;
                        end else begin
                            plot_q      <= 1'b0;
                            erase_q     <= 1'b0;
                            enemy_idx_q <= '0;
                            if (erase_q) begin
                                state_q   <= S_MOVE;
                                move_en_q <= 1'b1;
                            end else begin
                                state_q      <= S_DONE;
                                frame_done_q <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    // A held tick restarts immediately, with no IDLE cycle in between.
                    if (launch) begin
                        state_q      <= S_LOAD;
                        load_coord_q <= 1'b1;
                        pending_q    <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef FRAME_SCHED_OVERRUN_CNT_EN
    logic [7:0] overrun_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= '0;
        end else if (!bus.start) begin
            overrun_q <= '0;
        end else if ((state_q != S_IDLE) && bus.frame_tick && pending_q && (overrun_q != 8'hFF)) begin
            overrun_q <= overrun_q + 8'd1;
        end
    end

    assign bus.overrun_cnt = overrun_q;
`endif

    assign bus.load_coord      = load_coord_q;
    assign bus.move_en         = move_en_q;
    assign bus.plot            = plot_q;
    assign bus.erase           = erase_q;
    assign bus.datapath_select = dsel_q;
    assign bus.enemy_idx       = enemy_idx_q;
    assign bus.pix_idx         = pix_idx_q;
    assign bus.busy            = busy_q;
    assign bus.frame_done      = frame_done_q;

endmodule

// File: doc/frame_draw_scheduler.md
Name: frame_draw_scheduler

Overview:
Sequences the shared VGA plot path once per frame. Erases, then redraws, the player sprite and every visible enemy sprite. Arbitrates the single pixel port between the self and enemy datapaths by driving datapath_select, enemy_idx and pix_idx. Sits between the game FSM (start, frame_tick) and the datapath mux / plot output, and issues the coordinate-load and move strobes.

Parameters:
NUM_ENEMY, 10, number of enemy slots (width of vis).
SPRITE_PIX, 16, pixels per sprite (4x4); cycles per sprite pass.
IDX_W, 4, width of enemy_idx and pix_idx.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  game running; frames begin only while high
frame_tick  in  1  one-cycle pulse per frame (60 Hz)
vis  in  NUM_ENEMY  enemy visibility mask, bit i = slot i
load_coord  out  1  one-cycle strobe: datapaths latch coordinates
move_en  out  1  one-cycle strobe: y counters advance one step
plot  out  1  pixel write valid this cycle
erase  out  1  high during erase passes; downstream forces colour 3'b000
datapath_select  out  1  1 = self datapath, 0 = enemy datapath
enemy_idx  out  IDX_W  enemy slot currently drawn
pix_idx  out  IDX_W  pixel offset within sprite, 0..SPRITE_PIX-1
busy  out  1  high from LOAD through DONE
frame_done  out  1  one-cycle pulse in DONE

Behaviour:
- Reset (asynchronous, active-low): state IDLE. All outputs 0. pending cleared. vis_q cleared.
- States: IDLE, LOAD, ERASE_SELF, ERASE_ENEMY, MOVE, DRAW_SELF, DRAW_ENEMY, DONE.
- IDLE -> LOAD when start & (frame_tick | pending). Clears pending.
- LOAD: 1 cycle. load_coord=1. vis_q <= vis. -> ERASE_SELF.
- ERASE_SELF / DRAW_SELF:
  - SPRITE_PIX cycles with plot=1 and datapath_select=1.
  - pix_idx counts 0..SPRITE_PIX-1.
  - erase=1 only in ERASE_SELF.
- ERASE_ENEMY / DRAW_ENEMY:
  - Visits set bits of vis_q in ascending slot order.
  - Each visited slot takes SPRITE_PIX plot cycles with datapath_select=0 and enemy_idx=slot.
  - Clear slots take zero cycles; next set bit is found combinationally.
  - If vis_q==0, the state is skipped entirely.
  - erase=1 only in ERASE_ENEMY.
- After ERASE_ENEMY -> MOVE: 1 cycle, move_en=1. Then vis_q <= vis again, so destroyed or spawned enemies are reflected in the draw pass. -> DRAW_SELF -> DRAW_ENEMY -> DONE.
- DONE: 1 cycle, frame_done=1. -> IDLE.
- Frame length = 3 + 2*SPRITE_PIX*(1+popcount). Example: 2 visible enemies with defaults = 99 cycles.
- plot is low in LOAD, MOVE, DONE and IDLE.
- frame_tick while busy sets pending. Only one pending tick is held; further ticks are dropped.
- Pending tick with start high: LOAD is entered the cycle after DONE.
- start falling mid-frame: current frame completes normally. No new frame begins, and pending is cleared while start=0.
- Outputs are registered. pix_idx and enemy_idx are valid in the same cycle as plot.

Optional Feature:
FRAME_SCHED_OVERRUN_CNT_EN
- Defined: adds output overrun_cnt [7:0], reset 0.
  - Increments (saturating at 255) whenever frame_tick arrives while busy and pending is already set (a dropped tick).
  - Clears when start is low.
- Undefined: the port and counter are absent; dropped ticks are silent.

Decomposition:
- Shared package frame_sched_pkg holds:
  - state encoding typedef (3-bit enum)
  - SPRITE_PIX / NUM_ENEMY defaults
  - colour constant ERASE_COLOR=3'b000
- Natural sub-module: next_visible_slot, a combinational priority finder. Given mask and current index, it returns the next set bit above the index plus a found flag.
- Pixel counter and FSM stay in the top.

Test Plan:
- Reset mid-DRAW_ENEMY -> all outputs 0 immediately (async), state IDLE; next frame_tick with start=1 gives load_coord the following cycle.
- start=1, vis=10'b0000000101, one frame_tick:
  - 99-cycle frame, 96 plot cycles.
  - enemy_idx sequence 0 then 2 in both passes.
  - erase=1 for the first 48 plot cycles.
  - move_en is a single pulse between the passes; frame_done is asserted on the last cycle.
- vis=0 -> 35-cycle frame: ERASE_SELF 16, DRAW_SELF 16, datapath_select=1 on all plot cycles.
- vis changes from 10'b11 to 10'b01 during the erase pass -> erase visits slots 0,1; draw visits slot 0 only.
- Two frame_ticks during a frame -> exactly one back-to-back frame (LOAD the cycle after DONE). With FRAME_SCHED_OVERRUN_CNT_EN, overrun_cnt=1.
- start dropped mid-frame with a tick pending -> frame completes, frame_done pulses, stays IDLE, no further load_coord.
